// File: rtl/i2c_slave_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_controller_if
// Description : Bus-side and FIFO-side signal bundle of the I2C slave
//               controller. The slave modport is seen by the controller, the
//               master modport by whatever drives the bus and hosts the FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_slave_controller_if;
    logic       scl_in;          // raw SCL level
    logic       sda_in;          // raw SDA level
    logic       sda_out;         // 0 = pull SDA low, 1 = release
    logic [7:0] data_in;         // head of TX FIFO
    logic       tx_empty;        // TX FIFO is empty
    logic       fifo_tx_enable;  // one-cycle TX FIFO pop
    logic [7:0] rx_data;         // last received byte
    logic       rx_full;         // RX FIFO is full
    logic       fifo_rx_enable;  // one-cycle RX FIFO push

    modport slave (
        input  scl_in, sda_in, data_in, tx_empty, rx_full,
        output sda_out, fifo_tx_enable, rx_data, fifo_rx_enable
    );

    modport master (
        output scl_in, sda_in, data_in, tx_empty, rx_full,
        input  sda_out, fifo_tx_enable, rx_data, fifo_rx_enable
    );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_controller.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_controller
// Description : 7-bit-address I2C slave. Oversamples SCL/SDA on core_clk
//               (core_clk >= 8x SCL), detects START/STOP, receives bytes into
//               an external RX FIFO and transmits bytes from an external TX
//               FIFO. Optional general-call support is built when the macro
//               I2C_SLAVE_GCALL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  core_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [6:0]            own_address,
    output logic                  busy,
    i2c_slave_controller_if.slave bus
);

    // A synchronizer shorter than two flops is not safe; clamp silently.
    localparam int c_SYNC_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDRESS   = 3'd1,
        S_ADDR_ACK  = 3'd2,
        S_RX_DATA   = 3'd3,
        S_RX_ACK    = 3'd4,
        S_TX_DATA   = 3'd5,
        S_TX_ACK    = 3'd6,
        S_WAIT_STOP = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [c_SYNC_STAGES-1:0] r_scl_sync;
    logic [c_SYNC_STAGES-1:0] r_sda_sync;
    logic                     r_scl_prev;
    logic                     r_sda_prev;
    logic                     w_scl;
    logic                     w_sda;
    logic                     w_scl_rise;
    logic                     w_scl_fall;
    logic                     w_start;
    logic                     w_stop;

    // Synchronize the raw bus levels and keep one extra delayed copy for edges.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[c_SYNC_STAGES-2:0], bus.scl_in};
            r_sda_sync <= {r_sda_sync[c_SYNC_STAGES-2:0], bus.sda_in};
            r_scl_prev <= r_scl_sync[c_SYNC_STAGES-1];
            r_sda_prev <= r_sda_sync[c_SYNC_STAGES-1];
        end
    end

    assign w_scl      = r_scl_sync[c_SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[c_SYNC_STAGES-1];
    assign w_scl_rise =  w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl &  r_scl_prev;
    // SCL must be high on both samples so an SCL edge never looks like START/STOP.
    assign w_start    = w_scl & r_scl_prev &  r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev &  w_sda;

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_t     r_state,    w_state_nxt;
    logic [2:0] r_bit_cnt,  w_bit_cnt_nxt;
    logic [7:0] r_shift,    w_shift_nxt;
    logic       r_rw,       w_rw_nxt;      // R/W bit of the accepted address
    logic       r_phase,    w_phase_nxt;   // second half of an ACK slot / all 8 TX bits sent
    logic       r_acked,    w_acked_nxt;   // received byte will be ACKed
    logic       r_sda_out,  w_sda_out_nxt;
    logic [7:0] r_rx_data,  w_rx_data_nxt;
    logic       r_rx_push,  w_rx_push_nxt;
    logic       r_tx_pop,   w_tx_pop_nxt;
    logic       r_busy,     w_busy_nxt;

    logic [7:0] w_rx_byte;
    logic [7:0] w_tx_byte;
    logic       w_own_match;
    logic       w_gcall_match;

    // Byte as it will look once the bit on the current SCL rise is shifted in.
    assign w_rx_byte   = {r_shift[6:0], w_sda};
    // An empty TX FIFO is answered with all-ones (SDA released).
    assign w_tx_byte   = bus.tx_empty ? 8'hFF : bus.data_in;
    // Address 0 is reserved for general call and never matches as own address.
    assign w_own_match = (w_rx_byte[7:1] == own_address) && (w_rx_byte[7:1] != 7'd0);
`ifdef I2C_SLAVE_GCALL_EN
    // Only the write form of general call is accepted.
    assign w_gcall_match = (w_rx_byte == 8'h00);
`else
    assign w_gcall_match = 1'b0;
`endif

    // Register all protocol state and outputs.
    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd7;
            r_shift   <= 8'h00;
            r_rw      <= 1'b0;
            r_phase   <= 1'b0;
            r_acked   <= 1'b0;
            r_sda_out <= 1'b1;
            r_rx_data <= 8'h00;
            r_rx_push <= 1'b0;
            r_tx_pop  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_rw      <= w_rw_nxt;
            r_phase   <= w_phase_nxt;
            r_acked   <= w_acked_nxt;
            r_sda_out <= w_sda_out_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_rx_push <= w_rx_push_nxt;
            r_tx_pop  <= w_tx_pop_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next-state and output decode; bus conditions override the per-state logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_rw_nxt      = r_rw;
        w_phase_nxt   = r_phase;
        w_acked_nxt   = r_acked;
        w_sda_out_nxt = r_sda_out;
        w_rx_data_nxt = r_rx_data;
        w_rx_push_nxt = 1'b0;
        w_tx_pop_nxt  = 1'b0;
        w_busy_nxt    = r_busy;

        if (!enable) begin
            // Disabled: leave the bus alone entirely.
            w_state_nxt   = S_IDLE;
            w_sda_out_nxt = 1'b1;
            w_busy_nxt    = 1'b0;
            w_phase_nxt   = 1'b0;
            w_bit_cnt_nxt = 3'd7;
        end else if (w_start) begin
            // START (or repeated START) wins over a coincident STOP.
            w_state_nxt   = S_ADDRESS;
            w_sda_out_nxt = 1'b1;
            w_phase_nxt   = 1'b0;
            w_bit_cnt_nxt = 3'd7;
        end else if (w_stop) begin
            w_state_nxt   = S_IDLE;
            w_sda_out_nxt = 1'b1;
            w_busy_nxt    = 1'b0;
            w_phase_nxt   = 1'b0;
            w_bit_cnt_nxt = 3'd7;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_sda_out_nxt = 1'b1;
                end

                S_ADDRESS: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_rx_byte;
                        if (r_bit_cnt == 3'd0) begin
                            if (w_own_match || w_gcall_match) begin
                                w_state_nxt = S_ADDR_ACK;
                                w_rw_nxt    = w_sda;
                                w_busy_nxt  = 1'b1;
                                w_phase_nxt = 1'b0;
                            end else begin
                                w_state_nxt   = S_WAIT_STOP;
                                w_sda_out_nxt = 1'b1;
                                w_busy_nxt    = 1'b0;
                            end
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                        end
                    end
                end

                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            // Fall ending the R/W bit: start driving ACK.
                            w_sda_out_nxt = 1'b0;
                            w_phase_nxt   = 1'b1;
                        end else begin
                            // Fall ending the ACK bit: first data bit begins now.
                            w_phase_nxt   = 1'b0;
                            w_bit_cnt_nxt = 3'd7;
                            if (r_rw) begin
                                w_state_nxt   = S_TX_DATA;
                                w_shift_nxt   = w_tx_byte;
                                w_sda_out_nxt = w_tx_byte[7];
                                w_tx_pop_nxt  = ~bus.tx_empty;
                            end else begin
                                w_state_nxt   = S_RX_DATA;
                                w_sda_out_nxt = 1'b1;
                            end
                        end
                    end
                end

                S_RX_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_rx_byte;
                        if (r_bit_cnt == 3'd0) begin
                            // rx_data and the push pulse appear together next cycle.
                            w_rx_data_nxt = w_rx_byte;
                            w_rx_push_nxt = ~bus.rx_full;
                            w_acked_nxt   = ~bus.rx_full;
                            w_phase_nxt   = 1'b0;
                            w_state_nxt   = S_RX_ACK;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                        end
                    end
                end

                S_RX_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_out_nxt = ~r_acked;
                            w_phase_nxt   = 1'b1;
                        end else begin
                            w_sda_out_nxt = 1'b1;
                            w_phase_nxt   = 1'b0;
                            if (r_acked) begin
                                w_state_nxt   = S_RX_DATA;
                                w_bit_cnt_nxt = 3'd7;
                            end else begin
                                w_state_nxt = S_WAIT_STOP;
                                w_busy_nxt  = 1'b0;
                            end
                        end
                    end
                end

                S_TX_DATA: begin
                    if (w_scl_rise) begin
                        // r_phase marks that the master has clocked all 8 bits.
                        if (r_bit_cnt == 3'd0) begin
                            w_phase_nxt = 1'b1;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                        end
                    end else if (w_scl_fall) begin
                        if (r_phase) begin
                            w_sda_out_nxt = 1'b1;
                            w_phase_nxt   = 1'b0;
                            w_state_nxt   = S_TX_ACK;
                        end else begin
                            w_sda_out_nxt = r_shift[r_bit_cnt];
                        end
                    end
                end

                S_TX_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda) begin
                            // Master NACK: transfer over, wait for STOP.
                            w_state_nxt = S_WAIT_STOP;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_phase_nxt = 1'b1;
                        end
                    end else if (w_scl_fall && r_phase) begin
                        // Master ACK: fetch the next byte and drive its MSB.
                        w_state_nxt   = S_TX_DATA;
                        w_phase_nxt   = 1'b0;
                        w_bit_cnt_nxt = 3'd7;
                        w_shift_nxt   = w_tx_byte;
                        w_sda_out_nxt = w_tx_byte[7];
                        w_tx_pop_nxt  = ~bus.tx_empty;
                    end
                end

                S_WAIT_STOP: begin
                    w_sda_out_nxt = 1'b1;
                end

                default: begin
                    w_state_nxt   = S_IDLE;
                    w_sda_out_nxt = 1'b1;
                end
            endcase
        end
    end

    assign bus.sda_out        = r_sda_out;
    assign bus.rx_data        = r_rx_data;
    assign bus.fifo_rx_enable = r_rx_push;
    assign bus.fifo_tx_enable = r_tx_pop;
    assign busy               = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_controller
// Description : Directed bench for i2c_slave_controller. A bit-level bus
//               master drives transactions; a transaction-level model decides
//               what the slave must drive in every bit slot, which bytes it
//               must push and how many bytes it must pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_controller;

    localparam int Q = 8;   // core_clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [6:0] own_address;
    logic       busy;
    logic       scl_m;
    logic       sda_m;
    logic       rx_full_m;

    i2c_slave_controller_if bus ();

    // Open-drain bus: line is low if either side pulls it low.
    assign bus.scl_in  = scl_m;
    assign bus.sda_in  = sda_m & bus.sda_out;
    assign bus.rx_full = rx_full_m;

    i2c_slave_controller #(.SYNC_STAGES(2)) dut (
        .core_clk    (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .own_address (own_address),
        .busy        (busy),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // TX FIFO seen by the DUT.
    logic [7:0] tx_mem [0:15];
    int         tx_wr = 0;
    int         tx_rd = 0;
    assign bus.tx_empty = (tx_rd >= tx_wr);
    assign bus.data_in  = tx_mem[tx_rd[3:0]];
    always @(posedge clk)
        if (bus.fifo_tx_enable && (tx_rd < tx_wr)) tx_rd <= tx_rd + 1;

    // Transaction-level model state.
    logic [7:0] model_txq [$];
    logic [7:0] exp_push [$];
    logic [7:0] m_cur;
    logic       m_active = 1'b0;
    logic       m_read   = 1'b0;
    int         exp_pops = 0;
    int         pops_seen = 0;
    int         pushes_seen = 0;

    logic       chk_en  = 1'b0;
    logic       exp_sda = 1'b1;
    int         n_vec = 0;
    int         n_err = 0;

    // Per-cycle compare against the model.
    always begin
        @(posedge clk);
        #1;
        if (chk_en) begin
            n_vec++;
            if (bus.sda_out !== exp_sda) begin
                n_err++;
                $display("FAIL sda_slot t=%0t: sda_out=%b expected %b", $time, bus.sda_out, exp_sda);
            end
        end
        if (bus.fifo_rx_enable === 1'b1) begin
            pushes_seen++;
            n_vec++;
            if (exp_push.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_push t=%0t: rx_data=%h, no push expected", $time, bus.rx_data);
            end else begin
                logic [7:0] e;
                e = exp_push.pop_front();
                if (bus.rx_data !== e) begin
                    n_err++;
                    $display("FAIL push_data t=%0t: rx_data=%h expected %h", $time, bus.rx_data, e);
                end
            end
        end
        if (bus.fifo_tx_enable === 1'b1) pops_seen++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic addr_match(input logic [7:0] b);
        logic m;
        m = (b[7:1] == own_address) && (b[7:1] != 7'd0);
`ifdef I2C_SLAVE_GCALL_EN
        m = m || (b == 8'h00);
`endif
        return m;
    endfunction

    task automatic tx_push(input logic [7:0] b);
        tx_mem[tx_wr[3:0]] = b;
        tx_wr++;
        model_txq.push_back(b);
    endtask

    // Slave fetches its next transmit byte.
    task automatic m_load();
        if (model_txq.size() > 0) begin
            m_cur = model_txq.pop_front();
            exp_pops++;
        end else begin
            m_cur = 8'hFF;
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0;
        m_active = 1'b0;
    endtask

    task automatic bus_rstart();
        wait_q(); sda_m = 1'b1;
        wait_q(); scl_m = 1'b1;
        wait_q(); sda_m = 1'b0;
        wait_q(); scl_m = 1'b0;
        m_active = 1'b0;
    endtask

    task automatic bus_stop();
        wait_q(); sda_m = 1'b0;
        wait_q(); scl_m = 1'b1;
        wait_q(); sda_m = 1'b1;
        wait_q();
        m_active = 1'b0;
    endtask

    // One bit slot, entered just after SCL fell; slave value checked while it is stable.
    task automatic slot(input logic mbit, input logic slave_bit, output logic line);
        wait_q();
        exp_sda = slave_bit;
        chk_en  = 1'b1;
        sda_m   = mbit;
        wait_q(); scl_m = 1'b1;
        wait_q(); line = bus.sda_in;
        wait_q();
        chk_en = 1'b0;
        scl_m  = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic is_addr, output logic acked);
        logic line;
        logic exp_ack;
        if (is_addr) begin
            exp_ack  = addr_match(b);
            m_active = exp_ack;
            m_read   = b[0];
            if (exp_ack && b[0]) m_load();
        end else begin
            exp_ack = m_active && !m_read && !rx_full_m;
            if (exp_ack) exp_push.push_back(b);
            m_active = exp_ack;
        end
        for (int i = 7; i >= 0; i--) slot(b[i], 1'b1, line);
        slot(1'b1, ~exp_ack, line);
        acked = ~line;
    endtask

    task automatic rd_byte(input logic m_ack, output logic [7:0] got);
        logic       line;
        logic [7:0] exp_b;
        exp_b = (m_active && m_read) ? m_cur : 8'hFF;
        for (int i = 7; i >= 0; i--) begin
            slot(1'b1, exp_b[i], line);
            got[i] = line;
        end
        slot(~m_ack, 1'b1, line);
        if (m_active && m_read && m_ack) m_load();
        else m_active = 1'b0;
    endtask

    // Interrupt a write-data ACK slot halfway; caller applies the disturbance.
    task automatic write_until_ack(input logic [7:0] b);
        logic line;
        exp_push.push_back(b);
        for (int i = 7; i >= 0; i--) slot(b[i], 1'b1, line);
        wait_q();
    endtask

    task automatic finish_slot();
        wait_q(); scl_m = 1'b1;
        wait_q(); wait_q();
        scl_m = 1'b0;
        m_active = 1'b0;
    endtask

    initial begin
        logic       ack;
        logic [7:0] got;
        int         p0, q0;

        for (int i = 0; i < 16; i++) tx_mem[i] = 8'h00;
        rst_n = 1'b0; enable = 1'b1; own_address = 7'h50;
        scl_m = 1'b1; sda_m = 1'b1; rx_full_m = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_sda_out", bus.sda_out, 1);
        check("reset_rx_data", bus.rx_data, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_rx_push", bus.fifo_rx_enable, 0);
        check("reset_tx_pop", bus.fifo_tx_enable, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write 0xA0, 0x3C, STOP.
        p0 = pushes_seen;
        bus_start();
        wr_byte(8'hA0, 1'b1, ack); check("wr_addr_ack", ack, 1);
        check("wr_busy", busy, 1);
        wr_byte(8'h3C, 1'b0, ack); check("wr_data_ack", ack, 1);
        bus_stop(); repeat (4) @(negedge clk);
        check("wr_busy_after_stop", busy, 0);
        check("wr_rx_data", bus.rx_data, 8'h3C);
        check("wr_push_count", pushes_seen - p0, 1);

        // Read 0x11, 0x22 (ACK both), then empty FIFO byte NACKed.
        tx_push(8'h11); tx_push(8'h22);
        q0 = pops_seen;
        bus_start();
        wr_byte(8'hA1, 1'b1, ack); check("rd_addr_ack", ack, 1);
        rd_byte(1'b1, got); check("rd_byte0", got, 8'h11);
        rd_byte(1'b1, got); check("rd_byte1", got, 8'h22);
        rd_byte(1'b0, got); check("rd_byte_empty", got, 8'hFF);
        rd_byte(1'b0, got); check("rd_after_nack", got, 8'hFF);
        check("rd_busy_after_nack", busy, 0);
        bus_stop(); repeat (4) @(negedge clk);
        check("rd_pop_count", pops_seen - q0, 2);

        // Foreign address 0xA2.
        p0 = pushes_seen; q0 = pops_seen;
        bus_start();
        wr_byte(8'hA2, 1'b1, ack); check("miss_addr_nack", ack, 0);
        check("miss_busy", busy, 0);
        wr_byte(8'h55, 1'b0, ack); check("miss_data_nack", ack, 0);
        bus_stop(); repeat (4) @(negedge clk);
        check("miss_no_push", pushes_seen - p0, 0);
        check("miss_no_pop", pops_seen - q0, 0);

        // RX FIFO full on the second data byte.
        p0 = pushes_seen;
        bus_start();
        wr_byte(8'hA0, 1'b1, ack); check("full_addr_ack", ack, 1);
        wr_byte(8'h5A, 1'b0, ack); check("full_byte0_ack", ack, 1);
        rx_full_m = 1'b1;
        wr_byte(8'h6B, 1'b0, ack); check("full_byte1_nack", ack, 0);
        rx_full_m = 1'b0;
        bus_stop(); repeat (4) @(negedge clk);
        check("full_push_count", pushes_seen - p0, 1);
        check("full_rx_data", bus.rx_data, 8'h6B);

        // Partial write, repeated START, read from an empty TX FIFO.
        p0 = pushes_seen; q0 = pops_seen;
        bus_start();
        wr_byte(8'hA0, 1'b1, ack); check("rs_addr_ack", ack, 1);
        for (int i = 0; i < 4; i++) slot(i[0], 1'b1, ack);
        bus_rstart();
        wr_byte(8'hA1, 1'b1, ack); check("rs_read_ack", ack, 1);
        rd_byte(1'b0, got); check("rs_read_ff", got, 8'hFF);
        bus_stop(); repeat (4) @(negedge clk);
        check("rs_no_push", pushes_seen - p0, 0);
        check("rs_no_pop", pops_seen - q0, 0);

        // General call write, then general call read.
        p0 = pushes_seen;
        bus_start();
        wr_byte(8'h00, 1'b1, ack);
`ifdef I2C_SLAVE_GCALL_EN
        check("gcall_ack", ack, 1);
`else
        check("gcall_nack", ack, 0);
`endif
        wr_byte(8'h77, 1'b0, ack);
        bus_stop(); repeat (4) @(negedge clk);
`ifdef I2C_SLAVE_GCALL_EN
        check("gcall_push", pushes_seen - p0, 1);
`else
        check("gcall_no_push", pushes_seen - p0, 0);
`endif
        bus_start();
        wr_byte(8'h01, 1'b1, ack); check("gcall_read_nack", ack, 0);
        bus_stop(); repeat (4) @(negedge clk);

        // enable dropped while the slave holds ACK.
        bus_start();
        wr_byte(8'hA0, 1'b1, ack);
        write_until_ack(8'h12);
        check("en_ack_driven", bus.sda_out, 0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("en_released", bus.sda_out, 1);
        check("en_busy", busy, 0);
        enable = 1'b1;
        finish_slot();
        bus_stop(); repeat (4) @(negedge clk);

        // Asynchronous reset while the slave holds ACK.
        bus_start();
        wr_byte(8'hA0, 1'b1, ack);
        write_until_ack(8'h34);
        check("rst_ack_driven", bus.sda_out, 0);
        rst_n = 1'b0;
        #1;
        check("rst_sda_immediate", bus.sda_out, 1);
        check("rst_busy", busy, 0);
        check("rst_rx_data", bus.rx_data, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        finish_slot();
        bus_stop(); repeat (4) @(negedge clk);

        check("all_pushes_seen", exp_push.size(), 0);
        check("pop_total", pops_seen, exp_pops);
        check("pop_total_literal", pops_seen, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
